// File: rtl/s08_sci_pkg.sv
// rtl/s08_sci_pkg.sv - shared constants and state encoding for the SCI transmitter responder
package s08_sci_pkg;

    localparam int DEFAULT_DIV = 434;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIVL   = 2'd2;
    localparam logic [1:0] REG_DIVH   = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef SCI_TX_PARITY_EN
        PAR   = 3'd3,
`endif
        STOP  = 3'd4
    } tx_state_e;

endpackage

// File: rtl/sci_tx_responder_if.sv
// rtl/sci_tx_responder_if.sv - CPU register bus between the MiniS08 core and the SCI transmitter
interface sci_tx_responder_if;
    logic       sel;
    logic [1:0] regaddr;
    logic       read;
    logic       write;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output sel, output regaddr, output read, output write, output din, input dout);
    modport slave  (input sel, input regaddr, input read, input write, input din, output dout);
endinterface

// File: rtl/sci_tx_fifo.sv
// rtl/sci_tx_fifo.sv - synchronous transmit FIFO, a pop frees room for a push in the same cycle
module sci_tx_fifo
    import s08_sci_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // storage array, written only when the push is accepted
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/sci_tx_responder.sv
// rtl/sci_tx_responder.sv - CPU-mapped serial transmitter (8N1, or 8E1 when SCI_TX_PARITY_EN is defined)
module sci_tx_responder
    import s08_sci_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = s08_sci_pkg::DEFAULT_DIV
) (
    input  logic                clk50,
    input  logic                reset,
    sci_tx_responder_if.slave   bus,
    output logic                txd
);
    logic        wr_q, rd_q;
    logic        wr_edge, rd_edge;
    logic        push, pop;
    logic [7:0]  fifo_dout;
    logic        full, empty;
    logic        overflow_q;
    logic [15:0] div_q;
    logic [15:0] div_eff;
    logic        busy;
    logic        start_frame;

    tx_state_e   state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        timer_done;
`ifdef SCI_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // CPU strobes are held for many clk50 cycles, so act only on their rising edge
    assign wr_edge    = bus.sel & bus.write & ~wr_q;
    assign rd_edge    = bus.sel & bus.read & ~rd_q;
    assign push       = wr_edge & (bus.regaddr == REG_DATA);
    assign div_eff    = (div_q < 16'd2) ? 16'd2 : div_q;
    assign busy       = (state_q != IDLE);
    assign timer_done = (timer_q == 16'd0);
    assign txd        = txd_q;

    sci_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk50),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // edge-detect history, divisor registers and the sticky overflow flag
    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            overflow_q <= 1'b0;
            div_q      <= 16'(DEFAULT_DIV);
        end else begin
            wr_q <= bus.sel & bus.write;
            rd_q <= bus.sel & bus.read;
            if (wr_edge && bus.regaddr == REG_DIVL) begin
                div_q[7:0] <= bus.din;
            end
            if (wr_edge && bus.regaddr == REG_DIVH) begin
                div_q[15:8] <= bus.din;
            end
            if (rd_edge && bus.regaddr == REG_STATUS) begin
                overflow_q <= 1'b0;
            end
            // a same-cycle pop makes room, so only a push with no pop is dropped
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // read mux; the STATUS read shows overflow before the read edge clears it
    always_comb begin
        bus.dout = 8'h00;
        if (bus.sel && bus.read) begin
            case (bus.regaddr)
                REG_STATUS: begin
                    bus.dout[STAT_FULL]  = full;
                    bus.dout[STAT_EMPTY] = empty;
                    bus.dout[STAT_BUSY]  = busy;
                    bus.dout[STAT_OVF]   = overflow_q;
                end
                REG_DIVL: bus.dout = div_q[7:0];
                REG_DIVH: bus.dout = div_q[15:8];
                default:  bus.dout = 8'h00;
            endcase
        end
    end

    // transmitter state register; reset abandons any frame and returns txd high
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            div_lat_q <= 16'd2;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            txd_q     <= 1'b1;
`ifdef SCI_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_lat_q <= div_lat_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef SCI_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // next-state logic: each state lasts one bit period of the divisor latched at frame start
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_done ? (div_lat_q - 16'd1) : (timer_q - 16'd1);
        div_lat_d   = div_lat_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        pop         = 1'b0;
        start_frame = 1'b0;
`ifdef SCI_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d   = 1'b1;
                timer_d = timer_q;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (timer_done) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (timer_done) begin
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else begin
`ifdef SCI_TX_PARITY_EN
                        state_d = PAR;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end
                end
            end
`ifdef SCI_TX_PARITY_EN
            PAR: begin
                if (timer_done) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer_done) begin
                    if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // shared frame launch, from IDLE or straight out of STOP for gap-free frames
        if (start_frame) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            txd_d     = 1'b0;
            div_lat_d = div_eff;
            timer_d   = div_eff - 16'd1;
            state_d   = START;
`ifdef SCI_TX_PARITY_EN
            par_d     = ^fifo_dout;
`endif
        end
    end
endmodule

// File: tb/tb_sci_tx_responder.sv
// tb/tb_sci_tx_responder.sv - randomized scoreboard bench for sci_tx_responder
module tb_sci_tx_responder;
    import s08_sci_pkg::*;

    localparam int DEPTH = 4;
`ifdef SCI_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk50 = 1'b0;
    logic reset = 1'b1;
    logic txd;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    sci_tx_responder_if bus ();

    sci_tx_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus),
        .txd   (txd)
    );

    always #5 clk50 = ~clk50;
    always @(posedge clk50) cyc <= cyc + 1;

    // reference model: FIFO contents, frame schedule in edge numbers, flags
    logic [7:0]  mq[$];
    logic [7:0]  exp_q[$];
    logic        m_ovf;
    logic [15:0] m_div;
    int          m_next_pop;
    int          m_busy_until;

    function automatic int eff_div();
        return (m_div < 16'd2) ? 2 : int'(m_div);
    endfunction

    function automatic void model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf        = 1'b0;
        m_div        = 16'd434;
        m_next_pop   = 0;
        m_busy_until = 0;
    endfunction

    function automatic void model_advance(input int t);
        while (mq.size() > 0 && m_next_pop <= t) begin
            void'(mq.pop_front());
            m_busy_until = m_next_pop + NB * eff_div();
            m_next_pop   = m_busy_until;
        end
    endfunction

    function automatic void model_write(input int e, input logic [1:0] a, input logic [7:0] d);
        case (a)
            2'd0: begin
                model_advance(e);
                if (mq.size() < DEPTH) begin
                    if (mq.size() == 0) m_next_pop = (m_busy_until > e + 1) ? m_busy_until : e + 1;
                    mq.push_back(d);
                    exp_q.push_back(d);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            2'd2: m_div[7:0]  = d;
            2'd3: m_div[15:8] = d;
            default: ;
        endcase
    endfunction

    function automatic logic [7:0] model_status(input int e);
        logic busy;
        model_advance(e - 1);
        busy = (e - 1) < m_busy_until;
        return {4'b0000, m_ovf, busy, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    function automatic void check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", name, act, req);
        end
    endfunction

    // monitor: decodes frames on txd and compares them with the scoreboard queue
    bit              mon_active = 0;
    int              mon_k, mon_dv;
    logic [NB-1:0]   mon_bits;
    bit              mon_unstable;
    int              mon_frames = 0;
    int              mon_idle = 0;
    int              mon_gap_max = 0;
    bit              mon_first = 1;

    function automatic void finish_frame();
        logic [7:0] data, want;
        data = mon_bits[8:1];
        mon_frames++;
        checks++;
        if (mon_unstable) begin
            errors++;
            $display("FAIL bit_timing got unstable bit period expected %0d stable cycles", mon_dv);
        end
        checks++;
        if (mon_bits[NB-1] !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit got %b expected 1", mon_bits[NB-1]);
        end
`ifdef SCI_TX_PARITY_EN
        checks++;
        if (mon_bits[9] !== ^data) begin
            errors++;
            $display("FAIL parity_bit got %b expected %b", mon_bits[9], ^data);
        end
`endif
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got %02h expected none", data);
        end else begin
            want = exp_q.pop_front();
            if (data !== want) begin
                errors++;
                $display("FAIL frame_data got %02h expected %02h", data, want);
            end
        end
    endfunction

    always @(negedge clk50) begin
        if (reset) begin
            mon_active = 0;
            mon_idle   = 0;
        end else begin
            if (!mon_active && txd === 1'b0) begin
                mon_active   = 1;
                mon_k        = 0;
                mon_dv       = eff_div();
                mon_unstable = 0;
                if (!mon_first && mon_idle > mon_gap_max) mon_gap_max = mon_idle;
                mon_first = 0;
            end
            if (mon_active) begin
                if (mon_k % mon_dv == 0) mon_bits[mon_k / mon_dv] = txd;
                else if (txd !== mon_bits[mon_k / mon_dv]) mon_unstable = 1;
                mon_k++;
                if (mon_k == NB * mon_dv) begin
                    finish_frame();
                    mon_active = 0;
                    mon_idle   = 0;
                end
            end else begin
                mon_idle++;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold);
        @(posedge clk50); #1;
        bus.sel = 1'b1; bus.write = 1'b1; bus.regaddr = a; bus.din = d;
        model_write(cyc, a, d);
        repeat (hold) @(posedge clk50);
        #1;
        bus.sel = 1'b0; bus.write = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, input string name);
        logic [7:0] expv;
        int e;
        @(posedge clk50); #1;
        bus.sel = 1'b1; bus.read = 1'b1; bus.regaddr = a;
        e = cyc;
        case (a)
            2'd1:    expv = model_status(e);
            2'd2:    expv = m_div[7:0];
            2'd3:    expv = m_div[15:8];
            default: expv = 8'h00;
        endcase
        @(negedge clk50);
        check8(name, bus.dout, expv);
        if (a == REG_STATUS) m_ovf = 1'b0;
        @(posedge clk50); #1;
        bus.sel = 1'b0; bus.read = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 6000) begin
            @(negedge clk50);
            n++;
        end
        checks++;
        if (n >= 6000) begin
            errors++;
            $display("FAIL drain_timeout got %0d frames pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk50);
    endtask

    task automatic check_txd(input string name, input logic req);
        checks++;
        if (txd !== req) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, txd, req);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int f0;
        bus.sel = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.regaddr = 2'd0; bus.din = 8'h00;
        model_reset();
        repeat (2) @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        check_txd("reset_txd", 1'b1);
        read_reg(REG_STATUS, "reset_status");
        read_reg(REG_DIVL, "reset_divl");
        read_reg(REG_DIVH, "reset_divh");
        @(posedge clk50); #1;
        bus.sel = 1'b1; bus.regaddr = REG_STATUS;
        @(negedge clk50);
        check8("dout_unread", bus.dout, 8'h00);
        @(posedge clk50); #1 bus.sel = 1'b0;

        // serialize 0x55 at div 4 with first-bit latency
        bus_write(REG_DIVH, 8'h00, 1);
        bus_write(REG_DIVL, 8'h04, 1);
        read_reg(REG_DIVL, "divl_rw");
        bus_write(REG_DATA, 8'h55, 1);
        @(negedge clk50);
        check_txd("latency_pre", 1'b1);
        @(negedge clk50);
        check_txd("latency_fall", 1'b0);
        wait_drain();
        read_reg(REG_STATUS, "status_after_55");

        // level-held write acts once
        f0 = mon_frames;
        bus_write(REG_DATA, 8'hA5, 200);
        wait_drain();
        checks++;
        if (mon_frames - f0 != 1) begin
            errors++;
            $display("FAIL held_write_frames got %0d expected 1", mon_frames - f0);
        end
        read_reg(REG_STATUS, "status_after_held");

        // overflow: six quick pushes, one dropped, gap-free frames
        f0 = mon_frames;
        mon_first = 1;
        mon_gap_max = 0;
        for (int i = 0; i < 6; i++) bus_write(REG_DATA, 8'h10 + 8'(i), 1);
        read_reg(REG_STATUS, "ovf_status_first");
        read_reg(REG_STATUS, "ovf_status_second");
        wait_drain();
        checks++;
        if (mon_frames - f0 != 5 || mon_gap_max != 0) begin
            errors++;
            $display("FAIL ovf_frames got %0d frames gap %0d expected 5 frames gap 0", mon_frames - f0, mon_gap_max);
        end

        // parity-sensitive byte
        bus_write(REG_DATA, 8'h07, 1);
        wait_drain();

        // randomized bursts, divisors including the below-2 clamp
        for (int r = 0; r < 8; r++) begin
            bus_write(REG_DIVL, 8'($urandom_range(0, 6)), 1);
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                bus_write(REG_DATA, 8'($urandom), 1);
                repeat ($urandom_range(0, 12)) @(posedge clk50);
            end
            if ($urandom_range(0, 1) == 1) read_reg(REG_STATUS, "rand_status_mid");
            wait_drain();
            read_reg(REG_STATUS, "rand_status_end");
        end

        // reset during data bit 3 of a 0xFF frame
        bus_write(REG_DIVL, 8'h04, 1);
        bus_write(REG_DATA, 8'hFF, 1);
        repeat (18) @(posedge clk50);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk50);
        #1 reset = 1'b0;
        @(negedge clk50);
        check_txd("reset_mid_txd", 1'b1);
        read_reg(REG_STATUS, "reset_mid_status");
        read_reg(REG_DIVH, "reset_mid_divh");
        f0 = mon_frames;
        repeat (200) @(negedge clk50);
        checks++;
        if (mon_frames != f0 || mon_active) begin
            errors++;
            $display("FAIL reset_no_frames got %0d frames expected 0", mon_frames - f0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
